// File: rtl/pattern_sequencer.sv
// -----------------------------------------------------------------------------
// pattern_sequencer
//
// Programmable multi-channel LED pattern player. A small register-array memory
// holds DEPTH steps, each an LED on/off vector plus a duration in base ticks.
// A shared prescaler produces the base tick. Steps 0..last_idx are played a
// programmed number of passes (loops) or forever (loops == 0).
//
// Ports:
//   clk       - single clock
//   rst_n     - asynchronous active-low reset
//   wr_en     - pattern memory write strobe (allowed in any state)
//   wr_addr   - pattern memory write address
//   wr_data   - entry, packed {leds[NUM_CH-1:0], dur[DUR_W-1:0]}
//   last_idx  - index of the final step, sampled at start
//   loops     - number of passes (0 = forever), sampled at start
//   start     - single-cycle start request (ignored while playing)
//   stop      - single-cycle abort request (wins over start)
//   led       - registered LED drive
//   busy      - high while playing
//   step_idx  - registered index of the step being shown
//   done      - one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module pattern_sequencer #(
    parameter int TICK_DIV = 12_500_000,
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 32,
    parameter int DUR_W    = 4,
    parameter int LOOP_W   = 8,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_addr,
    input  logic [NUM_CH+DUR_W-1:0] wr_data,
    input  logic [IDX_W-1:0]        last_idx,
    input  logic [LOOP_W-1:0]       loops,
    input  logic                    start,
    input  logic                    stop,
    output logic [NUM_CH-1:0]       led,
    output logic                    busy,
    output logic [IDX_W-1:0]        step_idx,
    output logic                    done
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(DEPTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [NUM_CH+DUR_W-1:0] r_mem [DEPTH];

    logic [0:0]        r_state;
    logic [NUM_CH-1:0] r_led;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_last;
    logic [LOOP_W-1:0] r_loops;
    logic [LOOP_W-1:0] r_pass;
    logic [PRE_W-1:0]  r_pre;
    logic [DUR_W-1:0]  r_tcnt;
    logic [DUR_W-1:0]  r_dur;
    logic              r_done;

    logic                    w_wr_ok;
    logic [IDX_W-1:0]        w_last_clamp;
    logic [IDX_W-1:0]        w_rd_addr;
    logic [NUM_CH+DUR_W-1:0] w_entry;
    logic [NUM_CH-1:0]       w_leds;
    logic [DUR_W-1:0]        w_dur;
    logic [DUR_W-1:0]        w_dur_last;
    logic                    w_tick;
    logic                    w_step_end;
    logic [LOOP_W-1:0]       w_pass_nxt;

    // Address range only needs guarding when DEPTH is not a power of two;
    // otherwise every index is a valid entry and no clamp logic is built.
    if ((1 << IDX_W) == DEPTH) begin : g_pow2
        assign w_wr_ok      = wr_en;
        assign w_last_clamp = last_idx;
    end else begin : g_clamp
        assign w_wr_ok      = wr_en && (wr_addr <= LAST_MAX);
        assign w_last_clamp = (last_idx > LAST_MAX) ? LAST_MAX : last_idx;
    end

    // Pattern memory: no reset, written in any state. The read below sees the
    // pre-write contents when a write and a load hit the same address.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Entry that would be loaded on this edge: the next step, or entry 0 when
    // starting from IDLE or wrapping after the last step.
    assign w_rd_addr = (r_state == S_RUN && r_idx != r_last) ? r_idx + 1'b1 : '0;
    assign w_entry   = r_mem[w_rd_addr];
    assign w_leds    = w_entry[NUM_CH+DUR_W-1:DUR_W];
    assign w_dur     = w_entry[DUR_W-1:0];

    // A zero duration behaves as one tick.
    assign w_dur_last = (r_dur == '0) ? '0 : r_dur - 1'b1;
    assign w_tick     = (r_pre == PRE_MAX);
    assign w_step_end = w_tick && (r_tcnt == w_dur_last);
    assign w_pass_nxt = r_pass + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_loops <= '0;
            r_pass  <= '0;
            r_pre   <= '0;
            r_tcnt  <= '0;
            r_dur   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start && !stop) begin
                    r_state <= S_RUN;
                    r_last  <= w_last_clamp;
                    r_loops <= loops;
                    r_led   <= w_leds;
                    r_dur   <= w_dur;
                    r_idx   <= '0;
                    r_pre   <= '0;
                    r_tcnt  <= '0;
                    r_pass  <= '0;
                end
            end else begin
                if (stop) begin
                    r_state <= S_IDLE;
                    r_led   <= '0;
                    r_idx   <= '0;
                end else begin
                    // Prescaler free-runs while playing; a step always begins
                    // right after a wrap, so step lengths are exact multiples.
                    r_pre <= w_tick ? '0 : r_pre + 1'b1;
                    if (w_step_end) begin
                        r_tcnt <= '0;
                        if (r_idx != r_last || r_loops == '0) begin
                            r_led <= w_leds;
                            r_dur <= w_dur;
                            r_idx <= w_rd_addr;
                        end else begin
                            r_pass <= w_pass_nxt;
                            if (w_pass_nxt == r_loops) begin
                                r_state <= S_IDLE;
                                r_led   <= '0;
                                r_idx   <= '0;
                                r_done  <= 1'b1;
                            end else begin
                                r_led <= w_leds;
                                r_dur <= w_dur;
                                r_idx <= w_rd_addr;
                            end
                        end
                    end else if (w_tick) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
            end
        end
    end

    assign led      = r_led;
    assign busy     = (r_state == S_RUN);
    assign step_idx = r_idx;
    assign done     = r_done;

endmodule
